// File: rtl/stage_if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stage_if_pkg
// Description : Shared bus widths, I-cache geometry helpers and fetch FSM
//               state encoding for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package stage_if_pkg;

    localparam int STALL_BUS_W = 6;
    localparam int MEM_ADDR_W  = 32;
    localparam int INST_W      = 32;
    localparam int BYTE_W      = 8;

    typedef enum logic [0:0] {
        IF_IDLE  = 1'b0,
        IF_FETCH = 1'b1
    } if_state_e;

    function automatic int icache_index_w(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int icache_tag_w(input int entries);
        return MEM_ADDR_W - 2 - $clog2(entries);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stage_if_if.sv
`default_nettype none
// ============================================================================
// Module      : stage_if_if
// Description : Byte-serial read port between the fetch stage and the shared
//               memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface stage_if_if;
    import stage_if_pkg::*;

    logic                  mem_req_o;
    logic [MEM_ADDR_W-1:0] mem_addr_o;
    logic                  mem_grant_i;
    logic                  mem_valid_i;
    logic [BYTE_W-1:0]     mem_data_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_grant_i,
        input  mem_valid_i,
        input  mem_data_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_grant_i,
        output mem_valid_i,
        output mem_data_i
    );
endinterface
`default_nettype wire

// File: rtl/stage_if_icache_dm.sv
`default_nettype none
// ============================================================================
// Module      : icache_dm
// Description : Direct-mapped one-word-per-line instruction cache with
//               combinational read and a single synchronous write port.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_dm
    import stage_if_pkg::*;
#(
    parameter  int ENTRIES = 64,
    localparam int IDX_W   = icache_index_w(ENTRIES),
    localparam int TAG_W   = icache_tag_w(ENTRIES)
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic [IDX_W-1:0]  rd_index,
    output logic                   rd_valid,
    output logic [TAG_W-1:0]       rd_tag,
    output logic [INST_W-1:0]      rd_data,
    input  wire logic              we,
    input  wire logic [IDX_W-1:0]  wr_index,
    input  wire logic [TAG_W-1:0]  wr_tag,
    input  wire logic [INST_W-1:0] wr_data
);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag_mem  [ENTRIES];
    logic [INST_W-1:0]  r_data_mem [ENTRIES];

    // Only the valid bits need clearing; stale tag/data are never trusted.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
        end else if (we) begin
            r_valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (we) begin
            r_tag_mem[wr_index]  <= wr_tag;
            r_data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = r_valid[rd_index];
    assign rd_tag   = r_tag_mem[rd_index];
    assign rd_data  = r_data_mem[rd_index];

endmodule
`default_nettype wire

// File: rtl/stage_if.sv
`default_nettype none
// ============================================================================
// Module      : stage_if
// Description : Instruction-fetch stage: PC, I-cache lookup and byte-serial
//               miss refill from the shared memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_if
    import stage_if_pkg::*;
#(
    parameter int          ICACHE_ENTRIES = 64,
    parameter int          STALL_W        = STALL_BUS_W,
    parameter logic [31:0] RESET_PC       = 32'h0
) (
    input  wire logic               clock,
    input  wire logic               reset,
    input  wire logic [STALL_W-1:0] stall_i,
    input  wire logic               branch_i,
    input  wire logic [31:0]        branch_target_i,
    output logic [31:0]             pc_o,
    output logic [INST_W-1:0]       inst_o,
    output logic                    stall_req_o,
    stage_if_if.master              mem
);

    localparam int IDX_W = icache_index_w(ICACHE_ENTRIES);
    localparam int TAG_W = icache_tag_w(ICACHE_ENTRIES);

    if_state_e          r_state;
    if_state_e          w_state_nxt;
    logic [31:0]        r_pc;
    logic [2:0]         r_issue_cnt;
    logic [1:0]         r_recv_cnt;
    logic [2:0]         r_discard_cnt;
    logic [23:0]        r_buf;

    logic [IDX_W-1:0]   w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_line_valid;
    logic [TAG_W-1:0]   w_line_tag;
    logic [INST_W-1:0]  w_line_data;
    logic               w_hit;
    logic               w_req;
    logic               w_granted;
    logic               w_returned;
    logic               w_swallow;
    logic               w_abort;
    logic               w_last;
    logic               w_fill;
    logic [2:0]         w_outstanding;
    logic               w_unused_stall_bits;

    assign w_index = r_pc[IDX_W+1:2];
    assign w_tag   = r_pc[31:IDX_W+2];

    icache_dm #(
        .ENTRIES (ICACHE_ENTRIES)
    ) u_icache (
        .clock    (clock),
        .reset    (reset),
        .rd_index (w_index),
        .rd_valid (w_line_valid),
        .rd_tag   (w_line_tag),
        .rd_data  (w_line_data),
        .we       (w_fill),
        .wr_index (w_index),
        .wr_tag   (w_tag),
        .wr_data  ({mem.mem_data_i, r_buf})
    );

    assign w_hit      = w_line_valid && (w_line_tag == w_tag);
    assign w_abort    = reset || branch_i;
    // The first byte is requested straight from IDLE so a miss costs no idle cycle.
    assign w_req      = !reset && !w_hit && !r_issue_cnt[2];
    assign w_granted  = w_req && mem.mem_grant_i;
    assign w_swallow  = mem.mem_valid_i && (r_discard_cnt != 3'd0);
    assign w_returned = mem.mem_valid_i && (r_discard_cnt == 3'd0) && (r_state == IF_FETCH);
    assign w_last     = w_returned && (r_recv_cnt == 2'd3);
    assign w_fill     = w_last && !w_abort;
    assign w_outstanding = r_issue_cnt + {2'b00, w_granted}
                         - {1'b0, r_recv_cnt} - {2'b00, w_returned};

    assign w_unused_stall_bits = ^stall_i[STALL_W-1:1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IF_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IF_IDLE:  if (!w_hit) w_state_nxt = IF_FETCH;
            IF_FETCH: if (w_last) w_state_nxt = IF_IDLE;
            default:  w_state_nxt = IF_IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = IF_IDLE;
        end
    end

    // Aborts drop the fetch; beats already granted are swallowed by r_discard_cnt.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_issue_cnt   <= 3'd0;
            r_recv_cnt    <= 2'd0;
            r_discard_cnt <= w_outstanding;
        end else if (branch_i) begin
            r_issue_cnt   <= 3'd0;
            r_recv_cnt    <= 2'd0;
            r_discard_cnt <= r_discard_cnt - {2'b00, w_swallow} + w_outstanding;
        end else begin
            r_discard_cnt <= r_discard_cnt - {2'b00, w_swallow};
            if (w_last) begin
                r_issue_cnt <= 3'd0;
                r_recv_cnt  <= 2'd0;
            end else begin
                r_issue_cnt <= r_issue_cnt + {2'b00, w_granted};
                r_recv_cnt  <= r_recv_cnt + {1'b0, w_returned};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!w_abort && w_returned) begin
            case (r_recv_cnt)
                2'd0:    r_buf[7:0]   <= mem.mem_data_i;
                2'd1:    r_buf[15:8]  <= mem.mem_data_i;
                2'd2:    r_buf[23:16] <= mem.mem_data_i;
                default: r_buf        <= r_buf;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (branch_i) begin
            r_pc <= branch_target_i;
        end else if (w_hit && !stall_i[0]) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    assign pc_o           = reset ? RESET_PC : r_pc;
    assign inst_o         = (w_hit && !reset) ? w_line_data : '0;
    assign stall_req_o    = !reset && !w_hit;
    assign mem.mem_req_o  = w_req;
    assign mem.mem_addr_o = {r_pc[31:2], 2'b00} + {30'd0, r_issue_cnt[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_if
// Description : Directed self-checking bench for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_if;
    import stage_if_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  stall = 6'h00;
    logic        branch = 1'b0;
    logic [31:0] target = 32'h0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        stall_req;
    int          checks = 0;
    int          errors = 0;
    int          grant_mode = 0;
    int          gcnt = 0;

    always #5 clock = ~clock;

    stage_if_if mem_bus ();

    stage_if #(
        .ICACHE_ENTRIES (64),
        .STALL_W        (6),
        .RESET_PC       (32'h0)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .stall_i         (stall),
        .branch_i        (branch),
        .branch_target_i (target),
        .pc_o            (pc),
        .inst_o          (inst),
        .stall_req_o     (stall_req),
        .mem             (mem_bus)
    );

    // Memory image: 0x0 = 32'h00000513, 0x4 = 32'h00100593, elsewhere addr+0x11.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0: return 8'h13;
            32'h1: return 8'h05;
            32'h2: return 8'h00;
            32'h3: return 8'h00;
            32'h4: return 8'h93;
            32'h5: return 8'h05;
            32'h6: return 8'h10;
            32'h7: return 8'h00;
            default: return a[7:0] + 8'h11;
        endcase
    endfunction

    assign mem_bus.mem_grant_i = mem_bus.mem_req_o && ((grant_mode == 0) || (gcnt == 2));

    always @(posedge clock) begin
        mem_bus.mem_valid_i <= mem_bus.mem_req_o && mem_bus.mem_grant_i;
        mem_bus.mem_data_i  <= mem_byte(mem_bus.mem_addr_o);
        gcnt <= (mem_bus.mem_req_o && !mem_bus.mem_grant_i) ? gcnt + 1 : 0;
    end

    task automatic next();
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_if(input string tag, input logic [31:0] epc, input logic [31:0] einst,
                             input logic estall, input logic ereq, input logic [31:0] eaddr);
        chk({tag, ".pc"},        pc,                         epc);
        chk({tag, ".inst"},      inst,                       einst);
        chk({tag, ".stall_req"}, {31'd0, stall_req},         {31'd0, estall});
        chk({tag, ".mem_req"},   {31'd0, mem_bus.mem_req_o}, {31'd0, ereq});
        if (ereq) chk({tag, ".mem_addr"}, mem_bus.mem_addr_o, eaddr);
    endtask

    // Full-speed refill starting at the current (miss) cycle; ends on the hit cycle.
    task automatic fill(input string tag, input logic [31:0] base, input logic [31:0] word);
        for (int k = 0; k < 4; k++) begin
            expect_if({tag, ".issue"}, base, 32'h0, 1'b1, 1'b1, base + k);
            next();
        end
        expect_if({tag, ".wait"}, base, 32'h0, 1'b1, 1'b0, 32'h0);
        next();
        expect_if({tag, ".hit"}, base, word, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        repeat (2) next();
        expect_if("reset", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        #1;
        fill("cold0", 32'h0, 32'h00000513);
        next();
        fill("cold4", 32'h4, 32'h00100593);

        stall = 6'h01;
        for (int i = 0; i < 3; i++) begin
            next();
            expect_if("stall_hold", 32'h4, 32'h00100593, 1'b0, 1'b0, 32'h0);
        end
        stall = 6'h00;
        next();
        expect_if("stall_release", 32'h8, 32'h0, 1'b1, 1'b1, 32'h8);

        branch = 1'b1;
        target = 32'h0;
        next();
        branch = 1'b0;
        expect_if("hit_reuse0", 32'h0, 32'h00000513, 1'b0, 1'b0, 32'h0);
        next();
        expect_if("hit_reuse4", 32'h4, 32'h00100593, 1'b0, 1'b0, 32'h0);
        next();
        fill("fill8", 32'h8, 32'h1c1b1a19);

        branch = 1'b1;
        target = 32'h10;
        next();
        branch = 1'b0;
        expect_if("miss10_b0", 32'h10, 32'h0, 1'b1, 1'b1, 32'h10);
        next();
        expect_if("miss10_b1", 32'h10, 32'h0, 1'b1, 1'b1, 32'h11);
        branch = 1'b1;
        target = 32'h40;
        next();
        branch = 1'b0;
        fill("br40", 32'h40, 32'h54535251);

        branch = 1'b1;
        target = 32'h10;
        grant_mode = 1;
        next();
        branch = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < 3; c++) begin
                expect_if("backpressure", 32'h10, 32'h0, 1'b1, 1'b1, 32'h10 + b);
                next();
            end
        end
        expect_if("bp_wait", 32'h10, 32'h0, 1'b1, 1'b0, 32'h0);
        next();
        expect_if("bp_hit", 32'h10, 32'h24232221, 1'b0, 1'b0, 32'h0);

        grant_mode = 0;
        next();
        expect_if("miss14_b0", 32'h14, 32'h0, 1'b1, 1'b1, 32'h14);
        next();
        expect_if("miss14_b1", 32'h14, 32'h0, 1'b1, 1'b1, 32'h15);
        reset = 1'b1;
        next();
        expect_if("rst_mid1", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        next();
        expect_if("rst_mid2", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        #1;
        fill("rst_cold0", 32'h0, 32'h00000513);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stage_if.md
Name: stage_if

Overview:
- Instruction-fetch stage. Holds the architectural PC and supplies {pc, inst} to the IF/ID pipeline register.
- Hits are served from a small direct-mapped instruction cache.
- Misses are fetched byte-serially (little-endian, 4 bytes) from the shared memory controller, then the cache line is filled.
- Raises a stall request while no valid instruction is available. Accepts branch redirects from EX.

Parameters:
- ICACHE_ENTRIES, 64, number of one-word cache lines (power of 2).
- STALL_W, 6, width of the stall bus (the `StallBus` define).
- RESET_PC, 32'h0, PC value after reset.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- stall_i  in  STALL_W  stall bus from stall controller; bit 0 freezes the PC
- branch_i  in  1  redirect request from EX
- branch_target_i  in  32  redirect address
- pc_o  out  32  PC of the presented instruction
- inst_o  out  32  instruction word; 0 (bubble) when not valid
- stall_req_o  out  1  IF needs more cycles
- mem_req_o  out  1  byte-read request to memory controller
- mem_addr_o  out  32  byte address of request
- mem_grant_i  in  1  controller accepted this cycle's request
- mem_valid_i  in  1  returned byte valid; one cycle after the grant
- mem_data_i  in  8  returned byte

Behaviour:
- Reset:
  - pc <= RESET_PC; all cache valid bits cleared; FSM <= IDLE; issue/receive counters <= 0.
  - While reset is high: mem_req_o=0, stall_req_o=0, inst_o=0, pc_o=RESET_PC.
- Lookup (combinational on pc):
  - index = pc[log2(ENTRIES)+1:2].
  - tag = pc[31:log2(ENTRIES)+2].
- Hit:
  - inst_o = line data; pc_o = pc; stall_req_o=0.
  - At the clock edge, if !stall_i[0] and !branch_i: pc <= pc+4 (32-bit wrap).
  - If stall_i[0]: pc holds and outputs repeat.
- Miss:
  - inst_o=0; stall_req_o=1.
  - FSM leaves IDLE → FETCH with base = {pc[31:2],2'b00}.
- FETCH:
  - Issue counter k (0..3): mem_req_o=1, mem_addr_o=base+k. Each mem_grant_i increments k. mem_req_o drops after k=3 is granted.
  - Receive counter r: each mem_valid_i writes mem_data_i into byte r of the assembly buffer (byte0 → bits 7:0), then r++.
  - Issue and receive overlap: byte k+1 may be requested in the same cycle byte k returns.
  - When r=3 receives: write line {tag, buffer}, set valid, FSM → IDLE.
  - The next cycle is a hit.
  - Minimum miss penalty with a grant every cycle: request at t0, byte3 at t4, hit presented at t5.
- Misaligned pc (pc[1:0]≠0) is not supported; the branch source guarantees alignment.
- Branch (branch_i=1 at an edge), highest priority after reset:
  - pc <= branch_target_i regardless of stall_i[0].
  - FSM → IDLE; counters cleared.
  - Any byte already granted but not yet returned is dropped: a discard flag swallows exactly the outstanding mem_valid_i beats.
  - The partial buffer is discarded. No cache write occurs that cycle.
  - Branch in the same cycle as the final byte: the line fill is suppressed (simple, safe).
- Reset mid-fetch: same abort as a branch. Outstanding returns after reset are ignored; the discard counter is loaded with the number granted-unreturned.
- stall_i[0] during FETCH does not pause memory traffic. It only prevents pc advance on the hit.
- Cache is never invalidated except on reset (no self-modifying code).

Decomposition:
- Shared package / define.v:
  - `StallBus`, `MemAddrBus`, `InstBus`.
  - ICACHE index/tag width macros.
  - FSM state encodings IF_IDLE / IF_FETCH.
- Sub-module `icache_dm`:
  - Direct-mapped valid/tag/data arrays.
  - Combinational read; synchronous write port (we, addr, data); synchronous clear on reset.
- stage_if keeps the FSM, counters, discard logic and PC.

Test Plan:
- Cold fetch: reset, memory holds 13 05 00 00 at 0x0..0x3, grant every cycle → mem_addr_o 0,1,2,3 on t0–t3; stall_req_o=1 for t0–t4; at t5 inst_o=32'h00000513, pc_o=0.
- Hit reuse: after filling 0x0 and 0x4, branch to 0x0 → inst_o valid the following cycle with stall_req_o=0 and no mem_req_o.
- Stall hold: hit at pc=0x4 with stall_i[0]=1 for 3 cycles → pc_o stays 0x4, inst_o constant; release → pc_o=0x8 next cycle.
- Branch mid-fetch: miss at 0x10, branch_i to 0x40 after 2 bytes granted and 1 returned → late byte ignored, line 0x10 not valid, next mem_addr_o=0x40.
- Grant back-pressure: mem_grant_i low for 2 cycles between each byte → mem_addr_o held stable while ungranted; assembled word correct.
- Reset mid-fetch: assert reset with 1 byte outstanding → returned byte ignored, pc_o=RESET_PC, cache empty (next fetch misses).
